// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the arbitrated RAM: FSM state encoding and
// a clog2 variant that never returns zero, so 1-channel builds keep 1-bit fields.
package ram_arb_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_arb_mem_rr_arbiter.sv
// Round-robin arbiter: searches req starting at ptr, or grants only the
// owner when owner_en is set (burst lock). One-hot gnt plus encoded index.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int PTR_W = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             owner_en,
  input  logic [PTR_W-1:0] owner,
  output logic [NCH-1:0]   gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any_gnt
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    if (owner_en) begin
      if (req[owner]) begin
        gnt[owner] = 1'b1;
        gnt_idx    = owner;
        any_gnt    = 1'b1;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        idx = (int'(ptr) + i) % NCH;
        if (!any_gnt && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = PTR_W'(idx);
          any_gnt  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_arb_mem.sv
// Single-port synchronous RAM shared by NCH masters through a round-robin
// arbiter with optional burst locking; 1-cycle reads, sticky range error.
module ram_arb_mem
  import ram_arb_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int MAX_BURST = 4,
  localparam int PTR_W    = clog2_min1(NCH),
  localparam int BC_W     = clog2_min1(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        we,
  input  logic [NCH-1:0]        lock,
  input  logic [NCH*ADDR_W-1:0] addr,
  input  logic [NCH*DATA_W-1:0] wdata,
  output logic [NCH-1:0]        gnt,
  output logic [NCH-1:0]        rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output arb_state_e            dbg_state,
  output logic [PTR_W-1:0]      dbg_ptr,
  output logic [BC_W-1:0]       dbg_burst_cnt
);

  localparam int IDX_W = clog2_min1(DEPTH);

  // Handshake: a master holds req/we/lock/addr/wdata until it sees gnt[i]=1;
  // the access is accepted on that clock edge. A read answers with a one-cycle
  // rvalid[i] pulse and rdata on the following cycle.
  arb_state_e         state, state_nx;
  logic [PTR_W-1:0]   ptr, ptr_nx, owner, owner_nx, gnt_idx, ptr_inc;
  logic [BC_W-1:0]    bc, bc_nx;
  logic [NCH-1:0]     arb_req, arb_gnt;
  logic               arb_any, accept, we_sel, in_range;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [IDX_W-1:0]   mem_idx;
  logic [DATA_W-1:0]  mem [DEPTH];

  // During a burst only the owner may win, and only while it still holds lock.
  assign arb_req = (state == BURST) ? (req & lock) : req;

  rr_arbiter #(.NCH(NCH), .PTR_W(PTR_W)) u_arb (
    .req      (arb_req),
    .ptr      (ptr),
    .owner_en (state == BURST),
    .owner    (owner),
    .gnt      (arb_gnt),
    .gnt_idx  (gnt_idx),
    .any_gnt  (arb_any)
  );

  assign gnt       = rst ? arb_gnt : '0;
  assign accept    = rst & arb_any;
  assign we_sel    = we[gnt_idx];
  assign sel_addr  = addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_wdata = wdata[gnt_idx*DATA_W +: DATA_W];
  assign in_range  = ({1'b0, sel_addr} < (ADDR_W + 1)'(DEPTH));
  assign mem_idx   = sel_addr[IDX_W-1:0];
  assign ptr_inc   = (gnt_idx == PTR_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

  assign dbg_state     = state;
  assign dbg_ptr       = ptr;
  assign dbg_burst_cnt = bc;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    bc_nx    = bc;
    case (state)
      ARB: begin
        if (accept) begin
          ptr_nx = ptr_inc;
          if (lock[gnt_idx] && MAX_BURST > 1) begin
            state_nx = BURST;
            bc_nx    = BC_W'(1);
            owner_nx = gnt_idx;
          end
        end
      end
      BURST: begin
        if (accept) begin
          ptr_nx = ptr_inc;
          if ((bc + 1'b1) == BC_W'(MAX_BURST)) begin
            state_nx = ARB;
            bc_nx    = '0;
          end else begin
            bc_nx = bc + 1'b1;
          end
        end else begin
          state_nx = ARB;
          bc_nx    = '0;
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ARB;
      ptr    <= '0;
      owner  <= '0;
      bc     <= '0;
      rvalid <= '0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      owner  <= owner_nx;
      bc     <= bc_nx;
      rvalid <= (accept && !we_sel) ? arb_gnt : '0;
      if (accept && !we_sel) rdata <= in_range ? mem[mem_idx] : '0;
      if (accept && !in_range) err <= 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept && we_sel && in_range) mem[mem_idx] <= sel_wdata;
  end

endmodule

// File: tb/tb_ram_arb_mem.sv
// Directed bench for ram_arb_mem (NCH=2, DEPTH=256, MAX_BURST=4): a stepping
// driver checks grants and queues expected read responses for a monitor.
module tb_ram_arb_mem;
  import ram_arb_pkg::*;

  localparam int NCH = 2;
  localparam int DW  = 16;
  localparam int AW  = 16;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    req, we, lock;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    gnt, rvalid;
  logic [DW-1:0]     rdata;
  logic              err;
  arb_state_e        dbg_state;
  logic [0:0]        dbg_ptr;
  logic [2:0]        dbg_burst_cnt;

  logic [NCH+DW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  ram_arb_mem #(.NCH(NCH), .DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .MAX_BURST(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .we            (we),
    .lock          (lock),
    .addr          (addr),
    .wdata         (wdata),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rdata         (rdata),
    .err           (err),
    .dbg_state     (dbg_state),
    .dbg_ptr       (dbg_ptr),
    .dbg_burst_cnt (dbg_burst_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rvalid pulse must match the oldest queued response.
  always @(negedge clk) begin
    if (rvalid !== '0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'(rvalid), 32'h0);
      end else begin
        logic [NCH+DW-1:0] e;
        e = exp_q.pop_front();
        chk("rvalid", 32'(rvalid), 32'(e[NCH+DW-1:DW]));
        chk("rdata", 32'(rdata), 32'(e[DW-1:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1: drives one cycle, checks gnt mid-cycle, queues the
  // expected read response when erv is nonzero, returns at next posedge+1.
  task automatic step(input logic [1:0] rq, input logic [1:0] wen, input logic [1:0] lk,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] eg, input logic [1:0] erv, input logic [15:0] erd);
    req   = rq;
    we    = wen;
    lock  = lk;
    addr  = {a1, a0};
    wdata = {d1, d0};
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(eg));
    if (erv != 2'b00) exp_q.push_back({erv, erd});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 2'b00, 2'b00, 16'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;

    // Reset held with random inputs: outputs must stay quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      req   = 2'($urandom_range(0, 3));
      we    = 2'($urandom_range(0, 3));
      lock  = 2'($urandom_range(0, 3));
      addr  = {16'($urandom), 16'($urandom)};
      wdata = {16'($urandom), 16'($urandom)};
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata", 32'(rdata), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Write then read addr 5 on ch0; first request granted right after reset.
    step(2'b01, 2'b01, 2'b00, 16'd5, 16'd0, 16'hABCD, 16'h0, 2'b01, 2'b00, 16'h0);
    step(2'b01, 2'b00, 2'b00, 16'd5, 16'd0, 16'h0,    16'h0, 2'b01, 2'b01, 16'hABCD);
    // ch1 writes addr 7 (ptr=1 -> ch1).
    step(2'b10, 2'b10, 2'b00, 16'd0, 16'd7, 16'h0, 16'h1234, 2'b10, 2'b00, 16'h0);

    // Fairness: both read continuously, grants alternate from ptr=0.
    for (int i = 0; i < 2; i++) begin
      step(2'b11, 2'b00, 2'b00, 16'd5, 16'd7, 16'h0, 16'h0, 2'b01, 2'b01, 16'hABCD);
      step(2'b11, 2'b00, 2'b00, 16'd5, 16'd7, 16'h0, 16'h0, 2'b10, 2'b10, 16'h1234);
    end

    // ch0 writes addr 9, leaving ptr=1 so locked ch1 wins the next contest.
    step(2'b01, 2'b01, 2'b00, 16'd9, 16'd0, 16'h5555, 16'h0, 2'b01, 2'b00, 16'h0);

    // Burst: ch1 locked gets 4 grants while ch0 waits, then ch0 wins.
    step(2'b11, 2'b00, 2'b10, 16'd9, 16'd7, 16'h0, 16'h0, 2'b10, 2'b10, 16'h1234);
    chk("burst_state", 32'(dbg_state), 32'(BURST));
    chk("burst_cnt1", 32'(dbg_burst_cnt), 32'd1);
    for (int i = 0; i < 3; i++)
      step(2'b11, 2'b00, 2'b10, 16'd9, 16'd7, 16'h0, 16'h0, 2'b10, 2'b10, 16'h1234);
    chk("burst_exit_state", 32'(dbg_state), 32'(ARB));
    chk("burst_exit_ptr", 32'(dbg_ptr), 32'd0);
    step(2'b11, 2'b00, 2'b10, 16'd9, 16'd7, 16'h0, 16'h0, 2'b01, 2'b01, 16'h5555);
    idle();
    chk("post_burst_ptr", 32'(dbg_ptr), 32'd1);
    chk("post_burst_state", 32'(dbg_state), 32'(ARB));

    // Out-of-range read on ch1, then a valid write: err stays set.
    step(2'b10, 2'b00, 2'b00, 16'd0, 16'd300, 16'h0, 16'h0, 2'b10, 2'b10, 16'h0000);
    chk("err_set", 32'(err), 32'd1);
    step(2'b01, 2'b01, 2'b00, 16'd5, 16'd0, 16'h1111, 16'h0, 2'b01, 2'b00, 16'h0);
    idle();
    chk("err_sticky", 32'(err), 32'd1);

    // Reset right after a locked read is accepted: no rvalid, FSM back to ARB.
    step(2'b01, 2'b00, 2'b01, 16'd5, 16'd0, 16'h0, 16'h0, 2'b01, 2'b00, 16'h0);
    rst = 1'b0;
    req = '0; we = '0; lock = '0;
    @(negedge clk);
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_state", 32'(dbg_state), 32'(ARB));
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_ptr", 32'(dbg_ptr), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Memory survives reset.
    step(2'b01, 2'b00, 2'b00, 16'd5, 16'd0, 16'h0, 16'h0, 2'b01, 2'b01, 16'h1111);
    idle();
    idle();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
